// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: load-size encoding, register-file addressing and
// the write-back stage state encoding.
package mips_pkg;

  localparam int REG_ADDR_WIDTH = 5;
  localparam logic [REG_ADDR_WIDTH-1:0] ZERO_REG = '0;

  // Same encoding as the data-memory byte masks.
  typedef enum logic [1:0] {
    LS_WORD = 2'b00,
    LS_3B   = 2'b01,
    LS_HALF = 2'b10,
    LS_BYTE = 2'b11
  } load_size_t;

  typedef enum logic {
    ST_RUN,
    ST_HALTED
  } wb_state_t;

endpackage

// File: rtl/load_formatter.sv
// Sign/zero extension of zero-padded load data to a full register word.
// Purely combinational so any load path can reuse it.
module load_formatter
  import mips_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] data,
  input  logic [1:0]            size,
  input  logic                  load_unsigned,
  output logic [DATA_WIDTH-1:0] ext
);

  logic signed [7:0]  byte_s;
  logic signed [15:0] half_s;
  logic signed [23:0] tri_s;

  always_comb begin
    byte_s = signed'(data[7:0]);
    half_s = signed'(data[15:0]);
    tri_s  = signed'(data[23:0]);
    ext    = data;
    case (load_size_t'(size))
      LS_BYTE: ext = load_unsigned ? DATA_WIDTH'(data[7:0])  : DATA_WIDTH'(byte_s);
      LS_HALF: ext = load_unsigned ? DATA_WIDTH'(data[15:0]) : DATA_WIDTH'(half_s);
      LS_3B:   ext = load_unsigned ? DATA_WIDTH'(data[23:0]) : DATA_WIDTH'(tri_s);
      LS_WORD: ext = data;
      default: ext = data;
    endcase
  end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register: selects and formats write-back data, drives the
// register-file write port (also the forwarding source), counts retired ops, latches HALT.
module mem_wb_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int REG_ADDR_WIDTH = 5,
  parameter int CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_valid,
  input  logic                      i_stall,
  input  logic                      i_flush,
  input  logic                      i_reg_write,
  input  logic                      i_mem_to_reg,
  input  logic                      i_link,
  input  logic                      i_halt,
  input  logic [1:0]                i_load_size,
  input  logic                      i_load_unsigned,
  input  logic [REG_ADDR_WIDTH-1:0] i_rd,
  input  logic [DATA_WIDTH-1:0]     i_alu_result,
  input  logic [DATA_WIDTH-1:0]     i_mem_data,
  input  logic [DATA_WIDTH-1:0]     i_pc_link,
  output logic                      o_wb_en,
  output logic [REG_ADDR_WIDTH-1:0] o_wb_addr,
  output logic [DATA_WIDTH-1:0]     o_wb_data,
  output logic                      o_valid,
  output logic [CNT_WIDTH-1:0]      o_retired,
  output logic                      o_halted
);

  import mips_pkg::*;

  logic [DATA_WIDTH-1:0] load_ext;
  logic [DATA_WIDTH-1:0] wb_sel;
  logic                  wr_req;
  wb_state_t             state;

  load_formatter #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_load_formatter (
    .data          (i_mem_data),
    .size          (i_load_size),
    .load_unsigned (i_load_unsigned),
    .ext           (load_ext)
  );

  // Link beats load beats ALU; HALT never writes and $zero is never written.
  always_comb begin
    wb_sel = i_alu_result;
    if (i_link)
      wb_sel = i_pc_link;
    else if (i_mem_to_reg)
      wb_sel = load_ext;
    wr_req = i_valid & i_reg_write & ~i_halt & (i_rd != REG_ADDR_WIDTH'(ZERO_REG));
  end

  // MEM -> WB boundary
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RUN;
      o_valid   <= 1'b0;
      o_wb_en   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
      o_retired <= '0;
    end else if (state == ST_HALTED || i_flush) begin
      o_valid   <= 1'b0;
      o_wb_en   <= 1'b0;
      o_wb_addr <= '0;
      o_wb_data <= '0;
    end else if (!i_stall) begin
      o_valid   <= i_valid;
      o_wb_en   <= wr_req;
      o_wb_addr <= i_rd;
      o_wb_data <= wb_sel;
      if (i_valid)
        o_retired <= o_retired + CNT_WIDTH'(1);
      if (i_valid && i_halt)
        state <= ST_HALTED;
    end
  end

  assign o_halted = (state == ST_HALTED);

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scoreboard bench for mem_wb_stage: a driver pushes the expected post-edge state
// from a behavioural model, a monitor pops and compares after every clock edge.
module tb_mem_wb_stage;

  typedef struct packed {
    logic        valid, stall, flush, rw, m2r, link, halt;
    logic [1:0]  size;
    logic        uns;
    logic [4:0]  rd;
    logic [31:0] alu, mem, pc;
  } stim_t;

  typedef struct packed {
    logic        valid, en;
    logic [4:0]  addr;
    logic [31:0] data, retired;
    logic        halted;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        i_valid = 0, i_stall = 0, i_flush = 0, i_reg_write = 0;
  logic        i_mem_to_reg = 0, i_link = 0, i_halt = 0, i_load_unsigned = 0;
  logic [1:0]  i_load_size = 0;
  logic [4:0]  i_rd = 0;
  logic [31:0] i_alu_result = 0, i_mem_data = 0, i_pc_link = 0;
  logic        o_wb_en, o_valid, o_halted;
  logic [4:0]  o_wb_addr;
  logic [31:0] o_wb_data, o_retired;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t q[$];
  exp_t m;
  stim_t s;

  mem_wb_stage #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_stall(i_stall), .i_flush(i_flush),
    .i_reg_write(i_reg_write), .i_mem_to_reg(i_mem_to_reg), .i_link(i_link),
    .i_halt(i_halt), .i_load_size(i_load_size), .i_load_unsigned(i_load_unsigned),
    .i_rd(i_rd), .i_alu_result(i_alu_result), .i_mem_data(i_mem_data),
    .i_pc_link(i_pc_link), .o_wb_en(o_wb_en), .o_wb_addr(o_wb_addr),
    .o_wb_data(o_wb_data), .o_valid(o_valid), .o_retired(o_retired), .o_halted(o_halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, want);
    end
  endtask

  // Load value interpreted as an N-byte integer, then re-expressed as 32 bits.
  function automatic logic [31:0] fmt(input logic [31:0] d, input logic [1:0] sz, input logic uns);
    int     nb;
    longint v;
    nb = (sz == 2'b00) ? 4 : (sz == 2'b01) ? 3 : (sz == 2'b10) ? 2 : 1;
    v  = longint'(d) & ((longint'(1) << (8 * nb)) - 1);
    if (!uns && v >= (longint'(1) << (8 * nb - 1)))
      v = v - (longint'(1) << (8 * nb));
    return v[31:0];
  endfunction

  function automatic stim_t idle();
    stim_t t;
    t = '0;
    return t;
  endfunction

  function automatic stim_t rnd();
    stim_t t;
    t.valid = 1'($urandom_range(0, 3) != 0);
    t.stall = 1'($urandom_range(0, 9) == 0);
    t.flush = 1'($urandom_range(0, 9) == 0);
    t.rw    = 1'($urandom);
    t.m2r   = 1'($urandom);
    t.link  = 1'($urandom_range(0, 4) == 0);
    t.halt  = 1'b0;
    t.size  = 2'($urandom);
    t.uns   = 1'($urandom);
    t.rd    = 5'($urandom);
    t.alu   = $urandom;
    t.pc    = $urandom;
    t.mem   = $urandom;
    case (t.size)
      2'b01:   t.mem &= 32'h00FF_FFFF;
      2'b10:   t.mem &= 32'h0000_FFFF;
      2'b11:   t.mem &= 32'h0000_00FF;
      default: ;
    endcase
    return t;
  endfunction

  // Drives one instruction slot, predicts the state after the next edge, waits for the next negedge.
  task automatic apply(input stim_t t);
    i_valid = t.valid; i_stall = t.stall; i_flush = t.flush; i_reg_write = t.rw;
    i_mem_to_reg = t.m2r; i_link = t.link; i_halt = t.halt; i_load_size = t.size;
    i_load_unsigned = t.uns; i_rd = t.rd; i_alu_result = t.alu; i_mem_data = t.mem;
    i_pc_link = t.pc;
    if (m.halted || t.flush) begin
      m.valid = 0; m.en = 0; m.addr = 0; m.data = 0;
    end else if (!t.stall) begin
      m.valid = t.valid;
      m.en    = t.valid && t.rw && !t.halt && (t.rd != 0);
      m.addr  = t.rd;
      m.data  = t.link ? t.pc : t.m2r ? fmt(t.mem, t.size, t.uns) : t.alu;
      if (t.valid) m.retired = m.retired + 1;
      if (t.valid && t.halt) m.halted = 1;
    end
    q.push_back(m);
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_wb_en"},   32'(o_wb_en),   32'd0);
    chk({tag, "_wb_addr"}, 32'(o_wb_addr), 32'd0);
    chk({tag, "_wb_data"}, o_wb_data,      32'd0);
    chk({tag, "_valid"},   32'(o_valid),   32'd0);
    chk({tag, "_retired"}, o_retired,      32'd0);
    chk({tag, "_halted"},  32'(o_halted),  32'd0);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (rst) begin
      if (q.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL scoreboard_empty: edge with no expected entry");
      end else begin
        e = q.pop_front();
        chk("sb_valid",   32'(o_valid),   32'(e.valid));
        chk("sb_wb_en",   32'(o_wb_en),   32'(e.en));
        chk("sb_wb_addr", 32'(o_wb_addr), 32'(e.addr));
        chk("sb_wb_data", o_wb_data,      e.data);
        chk("sb_retired", o_retired,      e.retired);
        chk("sb_halted",  32'(o_halted),  32'(e.halted));
      end
    end
  end

  initial begin
    m = '0;
    #2;
    chk_reset_outputs("reset");
    repeat (2) @(negedge clk);
    rst = 1'b1;

    s = idle(); s.valid = 1; s.rw = 1; s.m2r = 1; s.size = 2'b11; s.rd = 5; s.mem = 32'h80;
    apply(s);
    chk("byte_s_data", o_wb_data, 32'hFFFF_FF80);
    chk("byte_s_addr", 32'(o_wb_addr), 32'd5);
    chk("byte_s_en", 32'(o_wb_en), 32'd1);
    s.size = 2'b10; s.uns = 1; s.mem = 32'h0000_ABCD;
    apply(s);
    chk("half_u_data", o_wb_data, 32'h0000_ABCD);
    s.uns = 0;
    apply(s);
    chk("half_s_data", o_wb_data, 32'hFFFF_ABCD);
    s.size = 2'b01; s.mem = 32'h0080_0000;
    apply(s);
    chk("tri_s_data", o_wb_data, 32'hFF80_0000);
    s = idle(); s.valid = 1; s.rw = 1; s.link = 1; s.m2r = 1; s.rd = 31;
    s.pc = 32'h40; s.mem = 32'h77; s.alu = 32'h99;
    apply(s);
    chk("jal_data", o_wb_data, 32'h40);
    s = idle(); s.valid = 1; s.rw = 1; s.rd = 0; s.alu = 32'h123;
    apply(s);
    chk("r0_en", 32'(o_wb_en), 32'd0);
    chk("r0_retired", o_retired, 32'd6);

    s = idle(); s.valid = 1; s.rw = 1; s.rd = 7; s.alu = 32'h1111;
    apply(s);
    for (int i = 0; i < 3; i++) begin
      s = rnd(); s.valid = 1; s.stall = 1; s.flush = 0;
      apply(s);
      chk("stall_hold_data", o_wb_data, 32'h1111);
      chk("stall_retired", o_retired, 32'd7);
    end
    s = rnd(); s.valid = 1; s.stall = 0; s.flush = 0;
    apply(s);
    s = rnd(); s.valid = 1; s.stall = 1; s.flush = 1;
    apply(s);
    chk("stall_flush_valid", 32'(o_valid), 32'd0);
    chk("stall_flush_retired", o_retired, 32'd8);

    for (int i = 0; i < 300; i++) apply(rnd());

    s = rnd(); s.stall = 1; s.flush = 0;
    apply(s);
    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst_stall");
    m = '0;
    @(negedge clk);
    rst = 1'b1;

    s = rnd(); s.valid = 1; s.halt = 1; s.flush = 1;
    apply(s);
    chk("halt_flush_halted", 32'(o_halted), 32'd0);
    for (int i = 0; i < 4; i++) begin
      s = rnd(); s.valid = 1; s.stall = 0; s.flush = 0;
      apply(s);
    end
    s = rnd(); s.valid = 1; s.halt = 1; s.rw = 1; s.rd = 9; s.stall = 0; s.flush = 0;
    apply(s);
    chk("halt_halted", 32'(o_halted), 32'd1);
    chk("halt_retired", o_retired, 32'd5);
    chk("halt_wb_en", 32'(o_wb_en), 32'd0);
    for (int i = 0; i < 10; i++) begin
      s = rnd(); s.valid = 1; s.rw = 1; s.rd = 3; s.stall = 0; s.flush = 0;
      apply(s);
      chk("halted_wb_en", 32'(o_wb_en), 32'd0);
      chk("halted_retired", o_retired, 32'd5);
    end

    #2 rst = 1'b0;
    #1 chk_reset_outputs("async_rst_halt");
    m = '0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 40; i++) apply(rnd());

    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
